// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
//   Zero-wait-state memory responder for a single-cycle CPU memory port.
//   Serves word-addressed RAM plus one 256-byte I/O page containing a GPIO
//   output register, a byte transmit FIFO and an optional free-running timer.
//   Read data is combinational so the CPU can latch it in the strobe cycle;
//   writes commit on the rising clock edge.
//
// Ports
//   iClk       clock, all state changes on the rising edge
//   nRst       asynchronous active-low reset (RAM contents are kept)
//   iMemAddr   byte address; bits [1:0] ignored
//   iMemData   write data
//   oMemData   combinational read data, 0 while iMemRead = 0
//   iMemRead   read strobe
//   iMemWrite  write strobe
//   oGPIO      GPIO output register
//   oTxData    byte at FIFO head (0 when empty)
//   oTxValid   FIFO not empty
//   iTxReady   sink accepts oTxData this cycle
//
// I/O page (word offsets from IO_BASE)
//   0x00 GPIO  0x04 TXDATA  0x08 TXSTAT  0x0C TIMER_CNT  0x10 TIMER_CTL
//
// Build option
//   MEM_RESPONDER_TIMER_EN  when defined, generates the timer at 0x0C/0x10;
//                           otherwise those addresses read 0 and ignore writes.
// ---------------------------------------------------------------------------
module mem_responder #(
    parameter int unsigned RAM_WORDS  = 1024,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [31:0] IO_BASE    = 32'hFFFF_0000
) (
    input  logic        iClk,
    input  logic        nRst,
    input  logic [31:0] iMemAddr,
    input  logic [31:0] iMemData,
    output logic [31:0] oMemData,
    input  logic        iMemRead,
    input  logic        iMemWrite,
    output logic [7:0]  oGPIO,
    output logic [7:0]  oTxData,
    output logic        oTxValid,
    input  logic        iTxReady
);

    localparam int unsigned AW = $clog2(RAM_WORDS);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    // I/O register word indices (iMemAddr[7:2])
    localparam logic [5:0] REG_GPIO   = 6'h00;
    localparam logic [5:0] REG_TXDATA = 6'h01;
    localparam logic [5:0] REG_TXSTAT = 6'h02;
`ifdef MEM_RESPONDER_TIMER_EN
    localparam logic [5:0] REG_TCNT   = 6'h03;
    localparam logic [5:0] REG_TCTL   = 6'h04;
`endif

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic          ram_hit;
    logic          io_hit;
    logic [AW-1:0] ram_idx;
    logic [5:0]    io_word;

    assign ram_hit = iMemAddr < 32'(RAM_WORDS * 4);
    assign io_hit  = iMemAddr[31:8] == IO_BASE[31:8];
    assign ram_idx = iMemAddr[AW+1:2];
    assign io_word = iMemAddr[7:2];

    logic wr_gpio, wr_txdata, wr_txstat;
    assign wr_gpio   = iMemWrite && io_hit && (io_word == REG_GPIO);
    assign wr_txdata = iMemWrite && io_hit && (io_word == REG_TXDATA);
    assign wr_txstat = iMemWrite && io_hit && (io_word == REG_TXSTAT);

    // ------------------------------------------------------------------
    // RAM
    // ------------------------------------------------------------------
    logic [31:0] ram_q [RAM_WORDS];

    // NOTE: memory arrays get no reset branch; a reset loop over every word
    // would turn the RAM into flops and is not what the CPU expects anyway.
    always_ff @(posedge iClk) begin
        if (iMemWrite && ram_hit) begin
            ram_q[ram_idx] <= iMemData;
        end
    end

    // ------------------------------------------------------------------
    // GPIO
    // ------------------------------------------------------------------
    logic [7:0] gpio_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            gpio_q <= 8'h00;
        end else if (wr_gpio) begin
            gpio_q <= iMemData[7:0];
        end
    end

    assign oGPIO = gpio_q;

    // ------------------------------------------------------------------
    // Transmit FIFO
    // ------------------------------------------------------------------
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          ovf_q,    ovf_d;
    logic          fifo_full, fifo_empty, pop, push_ok;

    assign fifo_empty = count_q == '0;
    assign fifo_full  = count_q == CW'(FIFO_DEPTH);
    assign pop        = !fifo_empty && iTxReady;
    // When full, the head leaving this cycle frees the slot being written.
    assign push_ok    = wr_txdata && (!fifo_full || pop);

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;

        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (wr_txstat && iMemData[2]) begin
            ovf_d = 1'b0;
        end
        if (wr_txdata && fifo_full && !pop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge iClk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_q] <= iMemData[7:0];
        end
    end

    // Head is masked while empty so stale storage never reaches the sink.
    assign oTxValid = !fifo_empty;
    assign oTxData  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr_q];

    // ------------------------------------------------------------------
    // Optional timer
    // ------------------------------------------------------------------
`ifdef MEM_RESPONDER_TIMER_EN
    logic [31:0] tcnt_q, tcnt_d;
    logic        trun_q, trun_d;
    logic        wr_tcnt, wr_tctl;

    assign wr_tcnt = iMemWrite && io_hit && (io_word == REG_TCNT);
    assign wr_tctl = iMemWrite && io_hit && (io_word == REG_TCTL);

    always_comb begin
        tcnt_d = tcnt_q;
        trun_d = trun_q;
        // A CPU load wins over the increment in the same cycle.
        if (wr_tcnt) begin
            tcnt_d = iMemData;
        end else if (trun_q) begin
            tcnt_d = tcnt_q + 32'd1;
        end
        if (wr_tctl) begin
            trun_d = iMemData[0];
        end
    end

    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            tcnt_q <= 32'h0;
            trun_q <= 1'b0;
        end else begin
            tcnt_q <= tcnt_d;
            trun_q <= trun_d;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Read mux (combinational, pre-write values)
    // ------------------------------------------------------------------
    always_comb begin
        oMemData = 32'h0;
        if (iMemRead) begin
            if (ram_hit) begin
                oMemData = ram_q[ram_idx];
            end else if (io_hit) begin
                case (io_word)
                    REG_GPIO:   oMemData = {24'h0, gpio_q};
                    REG_TXSTAT: oMemData = {16'h0, 8'(count_q), 5'h0,
                                            ovf_q, fifo_empty, fifo_full};
`ifdef MEM_RESPONDER_TIMER_EN
                    REG_TCNT:   oMemData = tcnt_q;
                    REG_TCTL:   oMemData = {31'h0, trun_q};
`endif
                    default:    oMemData = 32'h0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_responder
//   Self-checking bench for mem_responder. A behavioural model (associative
//   RAM, byte queue for the FIFO, plain registers for GPIO/timer) is updated
//   on each rising edge; one compare process checks every output on the
//   falling edge. Directed sequences pin the model with literal values, then
//   a randomized phase exercises the address map and FIFO flow control.
// ---------------------------------------------------------------------------
module tb_mem_responder;

    localparam int unsigned RAM_WORDS  = 1024;
    localparam int unsigned FIFO_DEPTH = 8;
    localparam logic [31:0] IO         = 32'hFFFF_0000;

    logic        iClk = 1'b0;
    logic        nRst = 1'b0;
    logic [31:0] iMemAddr = '0;
    logic [31:0] iMemData = '0;
    logic [31:0] oMemData;
    logic        iMemRead = 1'b0;
    logic        iMemWrite = 1'b0;
    logic [7:0]  oGPIO;
    logic [7:0]  oTxData;
    logic        oTxValid;
    logic        iTxReady = 1'b0;

    mem_responder #(
        .RAM_WORDS (RAM_WORDS),
        .FIFO_DEPTH(FIFO_DEPTH),
        .IO_BASE   (IO)
    ) dut (
        .iClk     (iClk),
        .nRst     (nRst),
        .iMemAddr (iMemAddr),
        .iMemData (iMemData),
        .oMemData (oMemData),
        .iMemRead (iMemRead),
        .iMemWrite(iMemWrite),
        .oGPIO    (oGPIO),
        .oTxData  (oTxData),
        .oTxValid (oTxValid),
        .iTxReady (iTxReady)
    );

    always #5 iClk = ~iClk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

`ifdef MEM_RESPONDER_TIMER_EN
    localparam bit TIMER = 1'b1;
`else
    localparam bit TIMER = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    logic [31:0] ram_m [int];
    logic [7:0]  gpio_m;
    logic [7:0]  q_m [$];
    bit          ovf_m;
    logic [31:0] tcnt_m;
    bit          trun_m;
    bit          m_pop;
    logic [31:0] m_off;

    function automatic bit is_io(input logic [31:0] a);
        return (a >= IO) && (a - IO < 32'd256);
    endfunction

    // Returns 1 when the expected read value is known (unwritten RAM is not).
    function automatic bit model_read(input logic [31:0] a, input logic rd, output logic [31:0] v);
        logic [31:0] off;
        v = 32'h0;
        if (!rd) return 1'b1;
        if (a < RAM_WORDS * 4) begin
            if (!ram_m.exists(int'(a / 4))) return 1'b0;
            v = ram_m[int'(a / 4)];
            return 1'b1;
        end
        if (!is_io(a)) return 1'b1;
        off = (a - IO) & ~32'h3;
        case (off)
            32'h00: v = {24'h0, gpio_m};
            32'h08: v = {16'h0, 8'(q_m.size()), 5'h0, ovf_m,
                         q_m.size() == 0, q_m.size() == FIFO_DEPTH};
            32'h0C: v = TIMER ? tcnt_m : 32'h0;
            32'h10: v = TIMER ? {31'h0, trun_m} : 32'h0;
            default: v = 32'h0;
        endcase
        return 1'b1;
    endfunction

    always @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            gpio_m = 8'h00;
            q_m.delete();
            ovf_m  = 1'b0;
            tcnt_m = 32'h0;
            trun_m = 1'b0;
        end else begin
            m_pop = (q_m.size() != 0) && iTxReady;
            m_off = (iMemAddr - IO) & ~32'h3;
            if (m_pop) void'(q_m.pop_front());
            if (TIMER && trun_m && !(iMemWrite && is_io(iMemAddr) && m_off == 32'h0C))
                tcnt_m = tcnt_m + 1;
            if (iMemWrite) begin
                if (iMemAddr < RAM_WORDS * 4) begin
                    ram_m[int'(iMemAddr / 4)] = iMemData;
                end else if (is_io(iMemAddr)) begin
                    case (m_off)
                        32'h00: gpio_m = iMemData[7:0];
                        32'h04: begin
                            // Pop already applied, so "full" here means full with no pop.
                            if (q_m.size() < FIFO_DEPTH) q_m.push_back(iMemData[7:0]);
                            else ovf_m = 1'b1;
                        end
                        32'h08: if (iMemData[2]) ovf_m = 1'b0;
                        32'h0C: if (TIMER) tcnt_m = iMemData;
                        32'h10: if (TIMER) trun_m = iMemData[0];
                        default: ;
                    endcase
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Compare process
    // ------------------------------------------------------------------
    always @(negedge iClk) begin
        logic [31:0] exp_rd;
        bit known;
        if (nRst && chk_en) begin
            known = model_read(iMemAddr, iMemRead, exp_rd);
            if (known) check("rdata", oMemData, exp_rd);
            check("gpio", {24'h0, oGPIO}, {24'h0, gpio_m});
            check("txvalid", {31'h0, oTxValid}, {31'h0, q_m.size() != 0});
            check("txdata", {24'h0, oTxData}, {24'h0, (q_m.size() != 0) ? q_m[0] : 8'h00});
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    // Applies inputs just after a rising edge; they hold for one cycle.
    task automatic set_in(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input logic rdy);
        @(posedge iClk);
        #1;
        iMemRead  = rd;
        iMemWrite = wr;
        iMemAddr  = a;
        iMemData  = d;
        iTxReady  = rdy;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge iClk);
        #1;
        check("rst_gpio", {24'h0, oGPIO}, 32'h0);
        check("rst_txvalid", {31'h0, oTxValid}, 32'h0);
        check("rst_txdata", {24'h0, oTxData}, 32'h0);
        nRst   = 1'b1;
        chk_en = 1'b1;

        // RAM write/read, ignored low address bits, idle read returns 0
        set_in(0, 1, 32'h10, 32'hDEADBEEF, 0);
        set_in(1, 0, 32'h10, 32'h0, 0);
        #1 check("ram_rd_10", oMemData, 32'hDEADBEEF);
        set_in(1, 0, 32'h13, 32'h0, 0);
        #1 check("ram_rd_13", oMemData, 32'hDEADBEEF);
        set_in(0, 0, 32'h10, 32'h0, 0);
        #1 check("rd_idle", oMemData, 32'h0);

        // Last RAM word and an unmapped address just past RAM
        set_in(0, 1, RAM_WORDS * 4 - 4, 32'h1234_5678, 0);
        set_in(0, 1, RAM_WORDS * 4, 32'hCAFE_F00D, 0);
        set_in(1, 0, RAM_WORDS * 4 - 4, 32'h0, 0);
        #1 check("ram_last", oMemData, 32'h1234_5678);
        set_in(1, 0, RAM_WORDS * 4, 32'h0, 0);
        #1 check("unmapped", oMemData, 32'h0);

        // GPIO, then asynchronous mid-cycle reset
        set_in(0, 1, IO, 32'h1A5, 0);
        set_in(0, 1, IO + 4, 32'h77, 0);
        set_in(1, 0, IO, 32'h0, 0);
        #1;
        check("gpio_val", {24'h0, oGPIO}, 32'hA5);
        check("gpio_rd", oMemData, 32'h0000_00A5);
        check("tx_before_rst", {23'h0, oTxValid, oTxData}, 32'h177);
        #1 nRst = 1'b0;
        #1;
        check("async_gpio", {24'h0, oGPIO}, 32'h0);
        check("async_tx", {23'h0, oTxValid, oTxData}, 32'h0);
        set_in(0, 0, 32'h0, 32'h0, 0);
        set_in(0, 0, 32'h0, 32'h0, 0);
        nRst = 1'b1;
        set_in(1, 0, 32'h10, 32'h0, 0);
        #1 check("ram_kept", oMemData, 32'hDEADBEEF);

        // FIFO push three, drain three
        set_in(0, 1, IO + 4, 32'h41, 0);
        set_in(0, 1, IO + 4, 32'h42, 0);
        set_in(0, 1, IO + 4, 32'h43, 0);
        set_in(1, 0, IO + 8, 32'h0, 0);
        #1;
        check("txstat_3", oMemData, 32'h0300);
        check("head_41", {24'h0, oTxData}, 32'h41);
        for (int i = 0; i < 3; i++) begin
            set_in(0, 0, 32'h0, 32'h0, 1);
            #1 check("drain", {23'h0, oTxValid, oTxData}, 32'h141 + i);
        end
        set_in(1, 0, IO + 8, 32'h0, 0);
        #1;
        check("empty_valid", {31'h0, oTxValid}, 32'h0);
        check("txstat_empty", oMemData, 32'h0002);

        // Overflow, ovf clear, push while full with pop
        for (int i = 0; i < 9; i++) set_in(0, 1, IO + 4, 32'h50 + i, 0);
        set_in(1, 0, IO + 8, 32'h0, 0);
        #1;
        check("txstat_ovf", oMemData, 32'h0805);
        check("head_50", {24'h0, oTxData}, 32'h50);
        set_in(0, 1, IO + 8, 32'h4, 0);
        set_in(1, 0, IO + 8, 32'h0, 0);
        #1 check("ovf_clear", oMemData, 32'h0801);
        set_in(0, 1, IO + 4, 32'h99, 1);
        set_in(1, 0, IO + 8, 32'h0, 0);
        #1;
        check("full_pushpop", oMemData, 32'h0801);
        check("head_51", {24'h0, oTxData}, 32'h51);
        for (int i = 0; i < FIFO_DEPTH; i++) set_in(0, 0, 32'h0, 32'h0, 1);
        set_in(0, 0, 32'h0, 32'h0, 0);
        #1 check("drained", {31'h0, oTxValid}, 32'h0);

        // Simultaneous read/write to the same RAM word
        set_in(0, 1, 32'h20, 32'h1, 0);
        set_in(1, 1, 32'h20, 32'h2, 0);
        #1 check("rw_old", oMemData, 32'h1);
        set_in(1, 0, 32'h20, 32'h0, 0);
        #1 check("rw_new", oMemData, 32'h2);

        // Timer (or unmapped when not built)
        set_in(0, 1, IO + 12, 32'hFFFF_FFFE, 0);
        set_in(0, 1, IO + 16, 32'h1, 0);
        set_in(1, 0, IO + 12, 32'h0, 0);
        #1 check("tmr_0", oMemData, TIMER ? 32'hFFFF_FFFE : 32'h0);
        set_in(1, 0, IO + 12, 32'h0, 0);
        #1 check("tmr_1", oMemData, TIMER ? 32'hFFFF_FFFF : 32'h0);
        set_in(1, 0, IO + 12, 32'h0, 0);
        #1 check("tmr_wrap", oMemData, 32'h0);
        set_in(1, 0, IO + 16, 32'h0, 0);
        #1 check("tmr_ctl", oMemData, TIMER ? 32'h1 : 32'h0);

        // Randomized phase
        for (int i = 0; i < 3000; i++) begin
            int unsigned sel;
            logic [31:0] a;
            sel = $urandom_range(0, 9);
            if (sel < 5)
                a = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
            else if (sel < 9)
                a = IO + ((32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3)));
            else
                a = ($urandom_range(0, 1) == 0) ? RAM_WORDS * 4 + (32'($urandom_range(0, 255)) << 2)
                                                : 32'h8000_0000 | 32'($urandom_range(0, 255));
            set_in(1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0, a, $urandom,
                   $urandom_range(0, 99) < ((i < 1500) ? 20 : 70));
        end
        set_in(0, 0, 32'h0, 32'h0, 0);
        @(posedge iClk);
        #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the CPU's single-cycle memory interface: address, write data, read data, read strobe, write strobe.
- Contains word-addressed RAM for instruction and data, plus a memory-mapped I/O page:
  - GPIO output register
  - byte transmit FIFO for a console/debug sink
  - optional free-running timer
- Zero wait states: read data is returned in the same cycle the strobe is asserted, because the CPU latches read data at the end of that cycle.

Parameters:
- RAM_WORDS, 1024, number of 32-bit RAM words; power of 2.
- FIFO_DEPTH, 8, transmit FIFO entries; power of 2, minimum 2.
- IO_BASE, 32'hFFFF_0000, base address of the I/O page; I/O decode is on addr[31:8] == IO_BASE[31:8].

Ports:
- iClk  in  1  clock; all state changes on rising edge.
- nRst  in  1  asynchronous active-low reset.
- iMemAddr  in  32  byte address from CPU; bits [1:0] are ignored (word access only).
- iMemData  in  32  write data from CPU.
- oMemData  out  32  read data to CPU, combinational.
- iMemRead  in  1  read strobe.
- iMemWrite  in  1  write strobe.
- oGPIO  out  8  GPIO output register.
- oTxData  out  8  byte at FIFO head.
- oTxValid  out  1  FIFO not empty.
- iTxReady  in  1  sink accepts oTxData this cycle.

Behaviour:
- Address map (word offsets):
  - RAM: addr < RAM_WORDS*4, index addr[log2(RAM_WORDS)+1:2].
  - IO+0x00 GPIO: R/W, low 8 bits.
  - IO+0x04 TXDATA: W pushes iMemData[7:0]; reads return 0.
  - IO+0x08 TXSTAT: R = {count[15:8], 5'b0, ovf[2], empty[1], full[0]}. W with bit2 = 1 clears ovf.
  - IO+0x0C TIMER_CNT.
  - IO+0x10 TIMER_CTL.
  - Unmapped reads return 0; unmapped writes are ignored.
- Read: oMemData is a combinational function of iMemAddr while iMemRead = 1, and 0 while iMemRead = 0.
- Write: takes effect at the rising edge when iMemWrite = 1.
- Read and write asserted together on the same address: the read returns the pre-write value; the write commits at the edge.
- RAM contents are not cleared by reset. All other state resets asynchronously:
  - oGPIO = 0
  - FIFO read/write pointers and count = 0, so oTxValid = 0 and oTxData = 0
  - ovf = 0
  - timer count and control = 0
- FIFO:
  - Circular buffer with wrap-around pointers and count 0..FIFO_DEPTH.
  - Pop occurs when oTxValid && iTxReady.
  - Push is accepted when count < FIFO_DEPTH, or when full with a pop in the same cycle (count unchanged).
  - A push while full with no pop is dropped, and ovf is set (sticky).
  - Push and pop in the same cycle while not full: count unchanged.
  - oTxData always shows the head entry; it is 0 when empty.
- Reset mid-transfer: the FIFO empties immediately and oTxValid drops asynchronously.

Optional Feature:
- Macro MEM_RESPONDER_TIMER_EN.
- Defined:
  - TIMER_CTL bit0 = run.
  - TIMER_CNT increments by 1 every cycle while run = 1 and wraps 0xFFFF_FFFF -> 0.
  - A CPU write to TIMER_CNT loads the written value and overrides the increment in that cycle.
  - Both registers are readable.
- Undefined: both addresses behave as unmapped (read 0, writes ignored), and no timer logic is generated.

Test Plan:
- Reset, then write RAM addr 0x10 = 0xDEADBEEF; read addr 0x10 and 0x13 -> oMemData = 0xDEADBEEF in the same cycle. With iMemRead = 0 -> oMemData = 0.
- Write IO+0x00 = 0x1A5 -> oGPIO = 0xA5 after the edge, and reading returns 0x000000A5. Assert nRst low mid-cycle -> oGPIO = 0 immediately.
- Push 0x41, 0x42, 0x43 with iTxReady = 0 -> TXSTAT = 0x0300, oTxData = 0x41. Raise iTxReady for 3 cycles -> bytes 0x41, 0x42, 0x43 in order, then oTxValid = 0 and TXSTAT = 0x0002.
- Push 9 bytes with iTxReady = 0 (DEPTH 8) -> 9th byte dropped, TXSTAT = 0x0805. Write TXSTAT = 0x4 -> ovf cleared (0x0801). Push while full with iTxReady = 1 -> accepted, count stays 8.
- Simultaneous read and write to RAM addr 0x20 (old 0x1, new 0x2) -> read returns 0x1; next read returns 0x2.
- MEM_RESPONDER_TIMER_EN: write CNT = 0xFFFF_FFFE, CTL = 1 -> reads 0xFFFF_FFFF, then 0x0. Without the macro -> reads 0.
